// File: rtl/axi_default_slave_pkg.sv
// Shared AXI definitions for the default slave: response codes, field widths
// and the read/write channel state encodings.
package axi_default_slave_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam int AXI_LEN_W   = 8;
   localparam int AXI_SIZE_W  = 3;
   localparam int AXI_BURST_W = 2;

   typedef enum logic {
      R_IDLE,
      R_DATA
   } rd_state_t;

   typedef enum logic [1:0] {
      W_IDLE,
      W_DATA,
      W_RESP
   } wr_state_t;

   // Saturating 16-bit increment used by the optional error counters.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/axi_default_slave_if.sv
// AXI4 bus bundle seen at the crossbar's default-slave port.
// The master modport drives requests; the slave modport answers them.
interface axi_default_slave_if
   import axi_default_slave_pkg::*;
#(
   parameter int ID_W   = 8,
   parameter int DATA_W = 32
) ();

   logic [ID_W-1:0]        AWID;
   logic [31:0]            AWADDR;
   logic [AXI_LEN_W-1:0]   AWLEN;
   logic [AXI_SIZE_W-1:0]  AWSIZE;
   logic [AXI_BURST_W-1:0] AWBURST;
   logic                   AWVALID;
   logic                   AWREADY;

   logic [DATA_W-1:0]      WDATA;
   logic [DATA_W/8-1:0]    WSTRB;
   logic                   WLAST;
   logic                   WVALID;
   logic                   WREADY;

   logic [ID_W-1:0]        BID;
   logic [1:0]             BRESP;
   logic                   BVALID;
   logic                   BREADY;

   logic [ID_W-1:0]        ARID;
   logic [31:0]            ARADDR;
   logic [AXI_LEN_W-1:0]   ARLEN;
   logic [AXI_SIZE_W-1:0]  ARSIZE;
   logic [AXI_BURST_W-1:0] ARBURST;
   logic                   ARVALID;
   logic                   ARREADY;

   logic [ID_W-1:0]        RID;
   logic [DATA_W-1:0]      RDATA;
   logic [1:0]             RRESP;
   logic                   RLAST;
   logic                   RVALID;
   logic                   RREADY;

   modport master (
      output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
      input  AWREADY,
      output WDATA, WSTRB, WLAST, WVALID,
      input  WREADY,
      input  BID, BRESP, BVALID,
      output BREADY,
      output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
      input  ARREADY,
      input  RID, RDATA, RRESP, RLAST, RVALID,
      output RREADY
   );

   modport slave (
      input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
      output AWREADY,
      input  WDATA, WSTRB, WLAST, WVALID,
      output WREADY,
      output BID, BRESP, BVALID,
      input  BREADY,
      input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
      output ARREADY,
      output RID, RDATA, RRESP, RLAST, RVALID,
      input  RREADY
   );

endinterface

// File: rtl/axi_default_slave_rd.sv
// Read channel of the default slave: accepts one AR at a time and returns
// ARLEN+1 zero-data DECERR beats, RLAST on the final one.
//
// state  | meaning
// -------+-----------------------------------------------------------
// R_IDLE | ARREADY high (from the first edge after reset), waiting AR
// R_DATA | RVALID high, streaming beats until the RLAST handshake
module axi_default_slave_rd
   import axi_default_slave_pkg::*;
#(
   parameter int ID_W   = 8,
   parameter int DATA_W = 32
) (
   input  logic                 ACLK,
   input  logic                 ARESETn,
   input  logic                 arvalid_i,
   input  logic [ID_W-1:0]      arid_i,
   input  logic [AXI_LEN_W-1:0] arlen_i,
   input  logic                 rready_i,
   output logic                 arready_o,
   output logic                 rvalid_o,
   output logic [ID_W-1:0]      rid_o,
   output logic [DATA_W-1:0]    rdata_o,
   output logic [1:0]           rresp_o,
   output logic                 rlast_o,
   output logic                 rd_done_o
);

   rd_state_t              state_q;
   logic                   arready_q;
   logic                   rvalid_q;
   logic                   rlast_q;
   logic [ID_W-1:0]        rid_q;
   logic [AXI_LEN_W-1:0]   len_q;
   logic [AXI_LEN_W-1:0]   beat_q;

   // Read FSM; RLAST is precomputed one beat ahead so it is a plain flop.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q   <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         rid_q     <= '0;
         len_q     <= '0;
         beat_q    <= '0;
      end else begin
         case (state_q)
            R_IDLE: begin
               arready_q <= 1'b1;
               if (arvalid_i && arready_q) begin
                  rid_q     <= arid_i;
                  len_q     <= arlen_i;
                  beat_q    <= '0;
                  rlast_q   <= (arlen_i == '0);
                  rvalid_q  <= 1'b1;
                  arready_q <= 1'b0;
                  state_q   <= R_DATA;
               end
            end
            R_DATA: begin
               if (rready_i) begin
                  if (rlast_q) begin
                     rvalid_q  <= 1'b0;
                     rlast_q   <= 1'b0;
                     arready_q <= 1'b1;
                     state_q   <= R_IDLE;
                  end else begin
                     // beat_q stops at len_q, so the +1 never wraps (ARLEN=255 -> 256 beats)
                     beat_q  <= beat_q + 8'd1;
                     rlast_q <= ((beat_q + 8'd1) == len_q);
                  end
               end
            end
         endcase
      end
   end

   assign arready_o = arready_q;
   assign rvalid_o  = rvalid_q;
   assign rid_o     = rid_q;
   assign rdata_o   = '0;
   assign rresp_o   = RESP_DECERR;
   assign rlast_o   = rlast_q;
   // Internal event for the optional burst counter only; not a bus output.
   assign rd_done_o = rvalid_q & rready_i & rlast_q;

endmodule

// File: rtl/axi_default_slave.sv
// AXI4 default slave: terminates every transaction routed to unmapped space
// with DECERR. Reads return zeros, write data is drained and dropped.
// Read and write channels are independent, one outstanding each.
// Optional feature: define DS_ERR_CNT_EN to add saturating 16-bit counters
// of completed read bursts (rd_err_cnt) and write responses (wr_err_cnt).
//
// state  | meaning
// -------+-----------------------------------------------------------
// W_IDLE | AWREADY high, WREADY low; W beats before AW are held off
// W_DATA | WREADY high, beats discarded until the WLAST handshake
// W_RESP | BVALID high with DECERR until BREADY
module axi_default_slave
   import axi_default_slave_pkg::*;
#(
   parameter int ID_W   = 8,
   parameter int DATA_W = 32
) (
   input  logic              ACLK,
   input  logic              ARESETn,
   axi_default_slave_if.slave s_axi
`ifdef DS_ERR_CNT_EN
   ,
   output logic [15:0]       rd_err_cnt,
   output logic [15:0]       wr_err_cnt
`endif
);

   wr_state_t         wstate_q;
   logic              awready_q;
   logic              wready_q;
   logic              bvalid_q;
   logic [ID_W-1:0]   bid_q;
   logic              rd_done;
   logic              wr_done;

   axi_default_slave_rd #(
      .ID_W   (ID_W),
      .DATA_W (DATA_W)
   ) u_rd (
      .ACLK      (ACLK),
      .ARESETn   (ARESETn),
      .arvalid_i (s_axi.ARVALID),
      .arid_i    (s_axi.ARID),
      .arlen_i   (s_axi.ARLEN),
      .rready_i  (s_axi.RREADY),
      .arready_o (s_axi.ARREADY),
      .rvalid_o  (s_axi.RVALID),
      .rid_o     (s_axi.RID),
      .rdata_o   (s_axi.RDATA),
      .rresp_o   (s_axi.RRESP),
      .rlast_o   (s_axi.RLAST),
      .rd_done_o (rd_done)
   );

   // Write FSM; burst length is not checked, WLAST alone ends the burst.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         wstate_q  <= W_IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bid_q     <= '0;
      end else begin
         case (wstate_q)
            W_IDLE: begin
               awready_q <= 1'b1;
               if (s_axi.AWVALID && awready_q) begin
                  bid_q     <= s_axi.AWID;
                  awready_q <= 1'b0;
                  wready_q  <= 1'b1;
                  wstate_q  <= W_DATA;
               end
            end
            W_DATA: begin
               if (s_axi.WVALID && s_axi.WLAST) begin
                  wready_q <= 1'b0;
                  bvalid_q <= 1'b1;
                  wstate_q <= W_RESP;
               end
            end
            W_RESP: begin
               if (s_axi.BREADY) begin
                  bvalid_q  <= 1'b0;
                  awready_q <= 1'b1;
                  wstate_q  <= W_IDLE;
               end
            end
            default: begin
               awready_q <= 1'b0;
               wready_q  <= 1'b0;
               bvalid_q  <= 1'b0;
               wstate_q  <= W_IDLE;
            end
         endcase
      end
   end

   assign s_axi.AWREADY = awready_q;
   assign s_axi.WREADY  = wready_q;
   assign s_axi.BVALID  = bvalid_q;
   assign s_axi.BID     = bid_q;
   assign s_axi.BRESP   = RESP_DECERR;

   assign wr_done = bvalid_q & s_axi.BREADY;

`ifdef DS_ERR_CNT_EN
   logic [15:0] rd_err_cnt_q, rd_err_cnt_d;
   logic [15:0] wr_err_cnt_q, wr_err_cnt_d;

   always_comb begin
      rd_err_cnt_d = rd_err_cnt_q;
      wr_err_cnt_d = wr_err_cnt_q;
      if (rd_done) rd_err_cnt_d = sat_inc16(rd_err_cnt_q);
      if (wr_done) wr_err_cnt_d = sat_inc16(wr_err_cnt_q);
   end

   // Terminated-burst counters, saturating so they never roll back to zero.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         rd_err_cnt_q <= '0;
         wr_err_cnt_q <= '0;
      end else begin
         rd_err_cnt_q <= rd_err_cnt_d;
         wr_err_cnt_q <= wr_err_cnt_d;
      end
   end

   assign rd_err_cnt = rd_err_cnt_q;
   assign wr_err_cnt = wr_err_cnt_q;
`else
   logic unused_done;
   assign unused_done = rd_done ^ wr_done;
`endif

   // Payload fields the default slave has no use for.
   logic unused_payload;
   assign unused_payload = ^{s_axi.AWADDR, s_axi.AWLEN, s_axi.AWSIZE, s_axi.AWBURST,
                             s_axi.WDATA, s_axi.WSTRB,
                             s_axi.ARADDR, s_axi.ARSIZE, s_axi.ARBURST};

endmodule
